// File: rtl/gol_next_gen.sv
// gol_next_gen: one Game of Life generation per start, swept row by row
// through a three-row window and written back in place to the row register file.
module gol_next_gen #(
   parameter int WIDTH   = 8,
   parameter int REGBITS = 3,
   parameter int CNTW    = 16
) (
   input  logic               ph1,
   input  logic               reset,
   input  logic               start,
   output logic [REGBITS-1:0] ra,
   input  logic [WIDTH-1:0]   rd,
   output logic               regwrite,
   output logic [REGBITS-1:0] wa,
   output logic [WIDTH-1:0]   wd,
   output logic               busy,
   output logic               done,
   output logic [CNTW-1:0]    gen_count
);
   typedef enum logic [2:0] {S_IDLE, S_LOAD0, S_FETCH, S_WRITE, S_DONE} state_t;
   localparam logic [REGBITS-1:0] LAST = '1;
   state_t             state_q, state_d;
   logic [REGBITS-1:0] r_q, r_d;
   logic [WIDTH-1:0]   above_q, above_d, cur_q, cur_d, below_q, below_d, nxt;
   logic [CNTW-1:0]    gen_q, gen_d;
   logic [WIDTH+1:0]   a_x, c_x, b_x;
   logic [3:0]         cnt;
   always_ff @(posedge ph1) begin
      if (reset) begin
         state_q <= S_IDLE;
         r_q     <= '0;
         above_q <= '0;
         cur_q   <= '0;
         below_q <= '0;
         gen_q   <= '0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         above_q <= above_d;
         cur_q   <= cur_d;
         below_q <= below_d;
         gen_q   <= gen_d;
      end
   end
   // zero-padded window rows give the dead left/right boundary
   always_comb begin
      a_x = {1'b0, above_q, 1'b0};
      c_x = {1'b0, cur_q, 1'b0};
      b_x = {1'b0, below_q, 1'b0};
      cnt = '0;
      nxt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt = {3'b0, a_x[i]} + {3'b0, a_x[i+1]} + {3'b0, a_x[i+2]}
             + {3'b0, c_x[i]} + {3'b0, c_x[i+2]}
             + {3'b0, b_x[i]} + {3'b0, b_x[i+1]} + {3'b0, b_x[i+2]};
         nxt[i] = (cnt == 4'd3) || (cnt == 4'd2 && cur_q[i]);
      end
   end
   always_comb begin
      state_d  = state_q;
      r_d      = r_q;
      above_d  = above_q;
      cur_d    = cur_q;
      below_d  = below_q;
      gen_d    = gen_q;
      ra       = '0;
      regwrite = 1'b0;
      wa       = '0;
      wd       = '0;
      done     = 1'b0;
      case (state_q)
         S_IDLE: if (start) begin
            r_d     = '0;
            state_d = S_LOAD0;
         end
         S_LOAD0: begin
            cur_d   = rd;
            above_d = '0;
            state_d = S_FETCH;
         end
         S_FETCH: begin
            ra      = r_q + 1'b1;
            below_d = (r_q == LAST) ? '0 : rd;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            regwrite = 1'b1;
            wa       = r_q;
            wd       = nxt;
            above_d  = cur_q;
            cur_d    = below_q;
            r_d      = (r_q == LAST) ? r_q : r_q + 1'b1;
            state_d  = (r_q == LAST) ? S_DONE : S_FETCH;
         end
         S_DONE: begin
            done    = 1'b1;
            gen_d   = gen_q + 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end
   assign busy      = (state_q != S_IDLE);
   assign gen_count = gen_q;
endmodule

// File: tb/tb_gol_next_gen.sv
// tb_gol_next_gen: random and directed grids against a cell-by-cell Life model,
// with a behavioural register file and a 4-bit-counter instance for wrap.
module tb_gol_next_gen;
   localparam int N = 8;
   typedef logic [7:0] grid_t [N];
   logic       ph1 = 0, reset = 1, start = 0;
   logic [2:0] ra, wa, ra4, wa4;
   logic [7:0] rd, wd, wd4;
   logic       regwrite, busy, done, regwrite4, busy4, done4;
   logic [15:0] gen_count;
   logic [3:0]  gen_count4;
   grid_t mem, exp_g;
   int n_chk = 0, n_fail = 0, exp_gen = 0;

   gol_next_gen dut (
      .ph1(ph1), .reset(reset), .start(start), .ra(ra), .rd(rd),
      .regwrite(regwrite), .wa(wa), .wd(wd), .busy(busy), .done(done),
      .gen_count(gen_count));
   gol_next_gen #(.CNTW(4)) dut4 (
      .ph1(ph1), .reset(reset), .start(start), .ra(ra4), .rd(8'h00),
      .regwrite(regwrite4), .wa(wa4), .wd(wd4), .busy(busy4), .done(done4),
      .gen_count(gen_count4));

   always #5 ph1 = ~ph1;
   assign rd = mem[ra];
   // register file commits during the second clock phase; reset restores the R-pentomino
   always @(negedge ph1) begin
      if (reset) begin
         for (int i = 0; i < N; i++) mem[i] = 8'h00;
         mem[0] = 8'h18;
         mem[1] = 8'h30;
         mem[2] = 8'h10;
      end else if (regwrite) mem[wa] = wd;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_next(input grid_t g, output grid_t n);
      int cnt, rr, cc;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < 8; c++) begin
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++) begin
                  rr = r + dr;
                  cc = c + dc;
                  if ((dr != 0 || dc != 0) && rr >= 0 && rr < N && cc >= 0 && cc < 8)
                     cnt += int'(g[rr][cc]);
               end
            n[r][c] = (cnt == 3) || (cnt == 2 && g[r][c]);
         end
   endtask

   task automatic run_gen(input bit extra_start);
      int wcnt = 0, dcnt = 0, dcnt4 = 0;
      model_next(mem, exp_g);
      @(negedge ph1);
      start = 1;
      for (int c = 1; c <= 2 * N + 3; c++) begin
         @(negedge ph1);
         start = extra_start && c == 5;
         if (c == 1) check("busy_latency", busy, 1);
         if (regwrite) begin
            check("wa_order", wa, wcnt);
            check("write_cycle", c, 2 * wcnt + 3);
            wcnt++;
         end
         if (done) begin
            dcnt++;
            check("done_cycle", c, 2 * N + 2);
         end
         if (done4) dcnt4++;
         if (c == 2 * N + 2) check("gen_count_hold", gen_count, exp_gen % 65536);
         if (c == 2 * N + 3) begin
            check("busy_fall", busy, 0);
            check("gen_count", gen_count, (exp_gen + 1) % 65536);
            check("gen_count4", gen_count4, (exp_gen + 1) % 16);
         end
      end
      exp_gen++;
      check("n_writes", wcnt, N);
      check("n_done", dcnt, 1);
      check("n_done4", dcnt4, 1);
      repeat (3) @(negedge ph1);
      check("idle_after", busy, 0);
      for (int r = 0; r < N; r++) check($sformatf("row%0d", r), mem[r], exp_g[r]);
   endtask

   task automatic load(input logic [7:0] v [N]);
      for (int i = 0; i < N; i++) mem[i] = v[i];
   endtask

   initial begin
      logic [7:0] g [N];
      bit seen;
      repeat (2) @(negedge ph1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_regwrite", regwrite, 0);
      check("rst_ra", ra, 0);
      check("rst_wa", wa, 0);
      check("rst_wd", wd, 0);
      check("rst_gen", gen_count, 0);
      reset = 0;
      run_gen(1);
      check("pent_r0", mem[0], 8'h38);
      check("pent_r1", mem[1], 8'h20);
      check("pent_r2", mem[2], 8'h30);
      check("pent_gen", gen_count, 1);
      g = '{default: 8'h00};
      g[7] = 8'he0;
      load(g);
      run_gen(0);
      check("blink_r6", mem[6], 8'h40);
      check("blink_r7", mem[7], 8'h40);
      g = '{default: 8'h00};
      g[0] = 8'h03;
      g[1] = 8'h03;
      load(g);
      run_gen(0);
      check("block_r0", mem[0], 8'h03);
      check("block_r1", mem[1], 8'h03);
      g = '{default: 8'hff};
      load(g);
      run_gen(0);
      check("full_r0", mem[0], 8'h81);
      check("full_r3", mem[3], 8'h00);
      check("full_r7", mem[7], 8'h81);
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < N; i++) g[i] = 8'($urandom);
         load(g);
         run_gen(k[0]);
      end
      @(negedge ph1);
      start = 1;
      seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge ph1);
         start = 0;
         seen = regwrite && wa == 3;
      end
      check("reach_row3", seen, 1);
      reset = 1;
      @(negedge ph1);
      check("midrst_busy", busy, 0);
      check("midrst_regwrite", regwrite, 0);
      check("midrst_gen", gen_count, 0);
      check("midrst_gen4", gen_count4, 0);
      reset = 0;
      exp_gen = 0;
      run_gen(0);
      check("post_rst_r0", mem[0], 8'h38);
      g = '{default: 8'h00};
      load(g);
      for (int k = 0; k < 16; k++) run_gen(0);
      check("wrap4", gen_count4, 1);
      for (int r = 0; r < N; r++) check("empty_stays", mem[r], 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/gol_next_gen.md
# gol_next_gen

Next-generation engine for the Game of Life datapath, directly upstream of the current-state row register file. On a `start` pulse it sweeps the grid row by row through the register file's combinational read port. It computes each row's next state from a three-row sliding window, then writes the result back in place through the write port. The grid has dead-cell boundaries with no wrap-around. A generation counter and `busy`/`done` status go to the top-level controller.

## Interface
- `WIDTH`, 8, cells per row (grid columns)
- `REGBITS`, 3, row-address width; rows N = 2**REGBITS
- `CNTW`, 16, generation-counter width
- `ph1`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  request one generation; sampled only in IDLE
- `ra`  out  REGBITS  register-file read address
- `rd`  in  WIDTH  register-file read data, combinational from `ra`
- `regwrite`  out  1  register-file write enable
- `wa`  out  REGBITS  register-file write address
- `wd`  out  WIDTH  register-file write data
- `busy`  out  1  high in every non-IDLE state
- `done`  out  1  one-cycle pulse when a generation completes
- `gen_count`  out  CNTW  completed generations since reset

## Operation
- Window registers: `above`, `cur`, `below` (WIDTH each); row index `r` (REGBITS).
- States:
  - IDLE: `ra`=0. If `start`, then `r`<=0 and go to LOAD0.
  - LOAD0: `ra`=0. Capture `cur`<=`rd`, `above`<=0. Go to FETCH.
  - FETCH: `ra`=`r`+1. If `r`<N-1, `below`<=`rd`; else `below`<=0 and `ra` is don't-care. Go to WRITE.
  - WRITE: `regwrite`=1, `wa`=`r`, `wd`=next(`above`,`cur`,`below`). Then `above`<=`cur`, `cur`<=`below`. If `r`==N-1 go to DONE; else `r`<=`r`+1 and go to FETCH.
  - DONE: `done`=1, `gen_count`<=`gen_count`+1 (wraps modulo 2**CNTW). Go to IDLE.
- In-place safety: row `r` is overwritten only after old row `r+1` has been captured. Old row `r` survives in `above`.
- Next-state rule, per bit i:
  - Neighbour count is bits i-1, i, i+1 of `above` and `below`, plus bits i-1, i+1 of `cur`.
  - Bits outside 0..WIDTH-1 count as 0.
  - Count is 4 bits wide, range 0..8.
  - Cell is alive next if count==3, or if count==2 and `cur`[i]==1.
- Outputs outside WRITE: `regwrite`=0, `wa`=0, `wd`=0.
- `start` while busy is ignored. No queuing.

## Timing
- Reset values: `busy`=0, `done`=0, `regwrite`=0, `ra`=0, `wa`=0, `wd`=0, `gen_count`=0, state IDLE, window registers 0.
- Latency: `start` high at edge k gives LOAD0 in cycle k+1 and `busy`=1 from cycle k+1.
- Each row takes two cycles, FETCH then WRITE. A generation occupies 2N+2 cycles: 18 for N=8.
- Write order: exactly N writes per generation, in order `wa`=0..N-1, on alternate cycles.
- `done` is asserted in cycle k+2N+2. `gen_count` shows the new value from cycle k+2N+3, when `busy` falls.
- Write handshake with the register file:
  - `regwrite`, `wa`, `wd` are registered-state decodes, stable for the whole WRITE cycle.
  - The register file commits them while ph2 is high.
- Reset mid-operation: on the next edge, return to IDLE with all reset values. `regwrite` drops at that edge. No partial write completes afterward. The register file reinitialises on the same `reset`.
- Back-to-back: DONE always returns to IDLE. The next `start` is sampled in IDLE, so minimum start-to-start spacing is 2N+3 cycles.

## Test plan
- Reset: assert `reset` 2 cycles -> `busy`=0, `done`=0, `regwrite`=0, `ra`=`wa`=`wd`=0, `gen_count`=0.
- R-pentomino: rows 0..2 = 0x18, 0x30, 0x10 (register-file reset pattern), rest 0. Pulse `start` -> rows become 0x38, 0x20, 0x30, 0, 0, 0, 0, 0. `done` pulses 18 cycles after start. 8 writes, `wa` 0..7 in order. `gen_count`=1.
- Boundary, no wrap: behavioural register-file model preloaded with row6=0, row7=0xE0 (horizontal blinker on bottom edge) -> row6=0x40, row7=0x40, all other rows 0. Corner block rows 0/1=0x03 -> unchanged.
- Full grid: all rows 0xFF -> row0=0x81, row7=0x81, rows 1..6=0x00. Empty grid stays all 0.
- Reset mid-op: assert `reset` during the WRITE of row 3 -> next cycle `busy`=0, `regwrite`=0, `gen_count`=0. A `start` pulse during `busy` is ignored: no extra generation, and `gen_count` advances by 1 only.
- Counter wrap: set CNTW=4 and run 16 generations on an empty grid -> `gen_count` goes 15 then 0, with one `done` pulse per generation.
